// File: rtl/mul_xbit_shift_add_pkg.sv
// Shared types and helpers for the shift-add multiplier.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mul_pkg;

    typedef enum logic [1:0] {
        MUL_IDLE,
        MUL_CALC,
        MUL_DONE
    } mul_state_t;

    // Step counter width: wide enough to hold 0..W.
    function automatic int mul_cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/mul_xbit_shift_add_adder.sv
// Carry-lookahead adder: 4-bit lookahead groups, carry rippled serially between groups.
// Latency: combinational, zero cycles.
// Backpressure: none (pure combinational).
// Ports: i_num_a/i_num_b operands, i_cry carry-in, o_res sum, o_cry carry-out.
module adder_xbit_ahead_serial #(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] i_num_a,
    input  logic [DATA_WIDTH-1:0] i_num_b,
    input  logic                  i_cry,
    output logic [DATA_WIDTH-1:0] o_res,
    output logic                  o_cry
);

    localparam int W = DATA_WIDTH;

    generate
        if ((W % 4) != 0 || W < 4) begin : g_bad_width
            $error("adder_xbit_ahead_serial: DATA_WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    logic [W-1:0] w_g;
    logic [W-1:0] w_p;
    logic [W:0]   w_c;

    assign w_g    = i_num_a & i_num_b;
    assign w_p    = i_num_a ^ i_num_b;
    assign w_c[0] = i_cry;

    // Inside each nibble every carry is a flat function of the group's
    // generate/propagate terms and the group carry-in.
    for (genvar gi = 0; gi < W / 4; gi++) begin : g_grp
        localparam int B = 4 * gi;
        assign w_c[B+1] = w_g[B]
                        | (w_p[B] & w_c[B]);
        assign w_c[B+2] = w_g[B+1]
                        | (w_p[B+1] & w_g[B])
                        | (w_p[B+1] & w_p[B] & w_c[B]);
        assign w_c[B+3] = w_g[B+2]
                        | (w_p[B+2] & w_g[B+1])
                        | (w_p[B+2] & w_p[B+1] & w_g[B])
                        | (w_p[B+2] & w_p[B+1] & w_p[B] & w_c[B]);
        assign w_c[B+4] = w_g[B+3]
                        | (w_p[B+3] & w_g[B+2])
                        | (w_p[B+3] & w_p[B+2] & w_g[B+1])
                        | (w_p[B+3] & w_p[B+2] & w_p[B+1] & w_g[B])
                        | (w_p[B+3] & w_p[B+2] & w_p[B+1] & w_p[B] & w_c[B]);
    end

    assign o_res = w_p ^ w_c[W-1:0];
    assign o_cry = w_c[W];

endmodule

// File: rtl/mul_xbit_shift_add.sv
// Unsigned W x W -> 2W shift-add multiplier, one partial product per cycle.
// Latency: o_vld rises exactly W cycles after the accept edge; W+2 cycles per op.
// Backpressure: o_rdy only in IDLE; result held in DONE until i_rdy.
// Ports: i_clk, i_rst_n (async, active-low), i_vld/o_rdy + i_num_a/i_num_b in,
//        o_vld/i_rdy + o_res (2W) out.
module mul_xbit_shift_add
    import mul_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_vld,
    output logic                    o_rdy,
    input  logic [DATA_WIDTH-1:0]   i_num_a,
    input  logic [DATA_WIDTH-1:0]   i_num_b,
    output logic                    o_vld,
    input  logic                    i_rdy,
    output logic [2*DATA_WIDTH-1:0] o_res
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = mul_cnt_width(W);
    localparam logic [CW-1:0] C_LAST = CW'(W - 1);

    generate
        if ((W % 4) != 0 || W < 4) begin : g_bad_width
            $error("mul_xbit_shift_add: DATA_WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    mul_state_t      r_state;
    logic [W-1:0]    r_a;
    logic [2*W-1:0]  r_p;      // {HI, LO}; LO starts as the multiplier
    logic [CW-1:0]   r_cnt;

    logic [W-1:0]    w_add_a;
    logic [W-1:0]    w_add_sum;
    logic            w_add_cry;

    // Add the multiplicand only when the current multiplier bit is set.
    assign w_add_a = r_p[0] ? r_a : '0;

    adder_xbit_ahead_serial #(
        .DATA_WIDTH (W)
    ) u_adder (
        .i_num_a (w_add_a),
        .i_num_b (r_p[2*W-1:W]),
        .i_cry   (1'b0),
        .o_res   (w_add_sum),
        .o_cry   (w_add_cry)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= MUL_IDLE;
            r_a     <= '0;
            r_p     <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                MUL_IDLE: begin
                    if (i_vld) begin
                        r_a     <= i_num_a;
                        r_p     <= {{W{1'b0}}, i_num_b};
                        r_cnt   <= '0;
                        r_state <= MUL_CALC;
                    end
                end
                MUL_CALC: begin
                    // Carry-out lands in the top bit before the right shift,
                    // so the 2W-bit register never overflows.
                    r_p   <= {w_add_cry, w_add_sum, r_p[W-1:1]};
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == C_LAST) begin
                        r_state <= MUL_DONE;
                    end
                end
                MUL_DONE: begin
                    if (i_rdy) begin
                        r_state <= MUL_IDLE;
                    end
                end
                default: begin
                    r_state <= MUL_IDLE;
                end
            endcase
        end
    end

    assign o_rdy = (r_state == MUL_IDLE);
    assign o_vld = (r_state == MUL_DONE);
    assign o_res = r_p;

endmodule

// File: tb/tb_mul_xbit_shift_add.sv
// Self-checking bench for mul_xbit_shift_add (W=8 main instance, W=16 corner instance).
// Directed cases for latency, carry, zeros, backpressure and async reset; then
// randomized handshakes against a transaction-level model of the multiplier.
module tb_mul_xbit_shift_add;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_vld;
    logic        o_rdy;
    logic [7:0]  i_num_a;
    logic [7:0]  i_num_b;
    logic        o_vld;
    logic        i_rdy;
    logic [15:0] o_res;

    logic        t_vld;
    logic        t_ordy;
    logic [15:0] t_a;
    logic [15:0] t_b;
    logic        t_ovld;
    logic        t_rdy;
    logic [31:0] t_res;

    int n_tests = 0;
    int n_fail  = 0;

    mul_xbit_shift_add #(.DATA_WIDTH(8)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_vld   (i_vld),
        .o_rdy   (o_rdy),
        .i_num_a (i_num_a),
        .i_num_b (i_num_b),
        .o_vld   (o_vld),
        .i_rdy   (i_rdy),
        .o_res   (o_res)
    );

    mul_xbit_shift_add #(.DATA_WIDTH(16)) dut16 (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_vld   (t_vld),
        .o_rdy   (t_ordy),
        .i_num_a (t_a),
        .i_num_b (t_b),
        .o_vld   (t_ovld),
        .i_rdy   (t_rdy),
        .o_res   (t_res)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    // One complete op with the consumer always ready; checks accept, latency,
    // product and the return to IDLE on the handshake edge.
    task automatic op_check(input logic [7:0] a, input logic [7:0] b,
                            input logic [15:0] exp, input string tag);
        int n;
        i_num_a = a;
        i_num_b = b;
        i_rdy   = 1'b1;
        chk({tag, "_rdy_pre"}, o_rdy, 1);
        i_vld = 1'b1;
        tick;
        i_vld = 1'b0;
        chk({tag, "_busy"}, o_rdy, 0);
        n = 0;
        while (!o_vld && n < 40) begin
            tick;
            n++;
        end
        chk({tag, "_lat"}, n, 8);
        chk({tag, "_res"}, o_res, exp);
        tick;
        chk({tag, "_vld_drop"}, o_vld, 0);
        chk({tag, "_idle"}, o_rdy, 1);
    endtask

    initial begin
        int          n;
        int          sent;
        int          got;
        int          cyc;
        int          gap;
        int          sel;
        bit          hold;
        bit          m_busy;
        int          m_age;
        logic [15:0] m_prod;
        logic [7:0]  ra;
        logic [7:0]  rb;

        i_rst_n = 1'b0;
        i_vld   = 1'b0;
        i_rdy   = 1'b0;
        i_num_a = '0;
        i_num_b = '0;
        t_vld   = 1'b0;
        t_rdy   = 1'b0;
        t_a     = '0;
        t_b     = '0;
        tick;
        tick;
        chk("rst_rdy", o_rdy, 1);
        chk("rst_vld", o_vld, 0);
        chk("rst_res", o_res, 0);
        chk("rst16_res", t_res, 0);
        i_rst_n = 1'b1;
        tick;

        // Basic, carry-heavy and zero-operand cases.
        op_check(8'd13,  8'd11,  16'h008F, "basic");
        op_check(8'd255, 8'd255, 16'hFE01, "max");
        op_check(8'd0,   8'd200, 16'h0000, "zero_a");
        op_check(8'd200, 8'd0,   16'h0000, "zero_b");
        op_check(8'd1,   8'd255, 16'h00FF, "one");

        // W=16 all-ones.
        t_a   = 16'hFFFF;
        t_b   = 16'hFFFF;
        t_rdy = 1'b1;
        t_vld = 1'b1;
        tick;
        t_vld = 1'b0;
        chk("w16_busy", t_ordy, 0);
        n = 0;
        while (!t_ovld && n < 60) begin
            tick;
            n++;
        end
        chk("w16_lat", n, 16);
        chk("w16_res", t_res, 32'hFFFE0001);
        tick;
        chk("w16_idle", t_ordy, 1);

        // Backpressure, with stray i_vld pulses during CALC and DONE.
        i_num_a = 8'd13;
        i_num_b = 8'd11;
        i_rdy   = 1'b0;
        i_vld   = 1'b1;
        tick;
        i_num_a = 8'd99;
        i_num_b = 8'd77;
        n = 0;
        while (!o_vld && n < 40) begin
            i_vld = 1'($urandom_range(0, 1));
            tick;
            n++;
        end
        chk("bp_lat", n, 8);
        for (int k = 0; k < 5; k++) begin
            i_vld = 1'b1;
            chk("bp_vld_hold", o_vld, 1);
            chk("bp_res_hold", o_res, 16'h008F);
            chk("bp_no_rdy", o_rdy, 0);
            tick;
        end
        chk("bp_vld_end", o_vld, 1);
        i_vld = 1'b0;
        i_rdy = 1'b1;
        tick;
        chk("bp_release_idle", o_rdy, 1);
        chk("bp_release_vld", o_vld, 0);
        op_check(8'd6, 8'd7, 16'd42, "bp_next");

        // Asynchronous reset in the middle of CALC.
        i_num_a = 8'd200;
        i_num_b = 8'd200;
        i_vld   = 1'b1;
        tick;
        i_vld = 1'b0;
        for (int k = 0; k < 4; k++) tick;
        chk("mid_busy", o_rdy, 0);
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("arst_vld", o_vld, 0);
        chk("arst_res", o_res, 0);
        chk("arst_rdy", o_rdy, 1);
        tick;
        i_rst_n = 1'b1;
        tick;
        op_check(8'd7, 8'd9, 16'h003F, "post_rst");

        // Randomized traffic. The model tracks one transaction at a time:
        // idle -> accepted -> W cycles of work -> result offered until taken.
        sent   = 0;
        got    = 0;
        cyc    = 0;
        gap    = 0;
        hold   = 1'b0;
        m_busy = 1'b0;
        m_age  = 0;
        m_prod = '0;
        ra     = '0;
        rb     = '0;
        i_vld  = 1'b0;
        while (got < 1000 && cyc < 60000) begin
            if (!hold) begin
                if (gap > 0) begin
                    gap--;
                    i_vld = 1'b0;
                end else if (sent < 1000) begin
                    sel = $urandom_range(0, 7);
                    ra  = (sel == 0) ? 8'h00 : (sel == 1) ? 8'hFF : 8'($urandom);
                    sel = $urandom_range(0, 7);
                    rb  = (sel == 0) ? 8'h00 : (sel == 1) ? 8'hFF : 8'($urandom);
                    i_num_a = ra;
                    i_num_b = rb;
                    i_vld   = 1'b1;
                    hold    = 1'b1;
                end else begin
                    i_vld = 1'b0;
                end
            end
            i_rdy = ($urandom_range(0, 3) != 0);
            chk("rnd_rdy", o_rdy, !m_busy);
            chk("rnd_vld", o_vld, m_busy && m_age >= 8);
            if (m_busy && m_age >= 8) chk("rnd_res", o_res, m_prod);
            tick;
            cyc++;
            if (!m_busy) begin
                if (i_vld) begin
                    m_busy = 1'b1;
                    m_age  = 0;
                    m_prod = 16'(ra) * 16'(rb);
                    sent++;
                    hold = 1'b0;
                    gap  = $urandom_range(0, 3);
                end
            end else if (m_age >= 8) begin
                if (i_rdy) begin
                    m_busy = 1'b0;
                    got++;
                end
            end else begin
                m_age++;
            end
        end
        chk("rnd_done_count", got, 1000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
